// File: rtl/qsys_system_nios2_qsys_0_div_cell_pkg.sv
// Shared types and constants for the Nios II multi-cycle divide cell.
// Latency is fixed by the FSM: one PREP, 32 ITER, one FIX and one DONE cycle.
package qsys_system_nios2_qsys_0_div_cell_pkg;

  localparam int DIV_WIDTH   = 32;
  localparam int DIV_LATENCY = 35;
  localparam int CNT_W       = 6;

  // PREP, FIX and DONE account for the cycles that are not iterations.
  localparam int                   ITER_CYCLES   = DIV_LATENCY - 3;
  localparam logic [CNT_W-1:0]     ITER_LAST     = CNT_W'(ITER_CYCLES - 1);
  localparam logic [DIV_WIDTH-1:0] DIV_ZERO_QUOT = 32'hFFFF_FFFF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PREP,
    ST_ITER,
    ST_FIX,
    ST_DONE
  } div_state_e;

  function automatic logic [DIV_WIDTH-1:0] neg_if(input logic                 neg,
                                                  input logic [DIV_WIDTH-1:0] v);
    return neg ? (~v + 1'b1) : v;
  endfunction

endpackage

// File: rtl/qsys_system_nios2_qsys_0_div_cell_step.sv
// One radix-2 restoring divide step: shift in the next dividend bit, trial
// subtract, and shift the resulting quotient bit into the low end of dq.
module qsys_system_nios2_qsys_0_div_step
  import qsys_system_nios2_qsys_0_div_cell_pkg::*;
(
  input  logic [DIV_WIDTH:0]   rem_i,
  input  logic [DIV_WIDTH-1:0] dq_i,
  input  logic [DIV_WIDTH-1:0] dvs_i,
  output logic [DIV_WIDTH:0]   rem_o,
  output logic [DIV_WIDTH-1:0] dq_o
);

  logic [DIV_WIDTH:0] rem_sh;
  logic [DIV_WIDTH:0] diff;
  logic               ge;
  logic               unused_rem_msb;

  // The partial remainder is always below the divisor, so its top bit is
  // zero on entry and only the low word needs shifting.
  assign unused_rem_msb = rem_i[DIV_WIDTH];

  assign rem_sh = {rem_i[DIV_WIDTH-1:0], dq_i[DIV_WIDTH-1]};
  assign ge     = (rem_sh >= {1'b0, dvs_i});
  assign diff   = rem_sh - {1'b0, dvs_i};
  assign rem_o  = ge ? diff : rem_sh;
  assign dq_o   = {dq_i[DIV_WIDTH-2:0], ge};

endmodule

// File: rtl/qsys_system_nios2_qsys_0_div_cell.sv
// Sequential 32-bit signed/unsigned divider: sign-magnitude conversion,
// 32 restoring iterations, sign fix-up, then a one-cycle done pulse.
module qsys_system_nios2_qsys_0_div_cell #(
  parameter int DIV_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 A_div_start,
  input  logic                 A_div_signed,
  input  logic [DIV_WIDTH-1:0] A_div_src1,
  input  logic [DIV_WIDTH-1:0] A_div_src2,
  output logic                 A_div_busy,
  output logic                 A_div_done,
  output logic [DIV_WIDTH-1:0] A_div_quotient,
  output logic [DIV_WIDTH-1:0] A_div_remainder
);

  import qsys_system_nios2_qsys_0_div_cell_pkg::*;

  div_state_e           state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [DIV_WIDTH-1:0] dq_q, dq_d;       // dividend bits shift out, quotient bits shift in
  logic [DIV_WIDTH-1:0] dvs_q, dvs_d;
  logic [DIV_WIDTH:0]   rem_q, rem_d;
  logic                 sgn_q, sgn_d;
  logic                 qneg_q, qneg_d;
  logic                 rneg_q, rneg_d;
  logic                 dz_q, dz_d;
  logic [DIV_WIDTH-1:0] quot_q, quot_d;
  logic [DIV_WIDTH-1:0] remo_q, remo_d;

  logic [DIV_WIDTH:0]   rem_step;
  logic [DIV_WIDTH-1:0] dq_step;

  qsys_system_nios2_qsys_0_div_step u_step (
    .rem_i (rem_q),
    .dq_i  (dq_q),
    .dvs_i (dvs_q),
    .rem_o (rem_step),
    .dq_o  (dq_step)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      dq_q    <= '0;
      dvs_q   <= '0;
      rem_q   <= '0;
      sgn_q   <= 1'b0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      dz_q    <= 1'b0;
      quot_q  <= '0;
      remo_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dq_q    <= dq_d;
      dvs_q   <= dvs_d;
      rem_q   <= rem_d;
      sgn_q   <= sgn_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      dz_q    <= dz_d;
      quot_q  <= quot_d;
      remo_q  <= remo_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dq_d    = dq_q;
    dvs_d   = dvs_q;
    rem_d   = rem_q;
    sgn_d   = sgn_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    dz_d    = dz_q;
    quot_d  = quot_q;
    remo_d  = remo_q;

    case (state_q)
      ST_IDLE: begin
        if (A_div_start) begin
          dq_d    = A_div_src1;
          dvs_d   = A_div_src2;
          sgn_d   = A_div_signed;
          state_d = ST_PREP;
        end
      end
      ST_PREP: begin
        dq_d    = neg_if(sgn_q & dq_q[DIV_WIDTH-1], dq_q);
        dvs_d   = neg_if(sgn_q & dvs_q[DIV_WIDTH-1], dvs_q);
        qneg_d  = sgn_q & (dq_q[DIV_WIDTH-1] ^ dvs_q[DIV_WIDTH-1]);
        rneg_d  = sgn_q & dq_q[DIV_WIDTH-1];
        dz_d    = (dvs_q == '0);
        rem_d   = '0;
        cnt_d   = '0;
        state_d = ST_ITER;
      end
      ST_ITER: begin
        rem_d = rem_step;
        dq_d  = dq_step;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == ITER_LAST) state_d = ST_FIX;
      end
      ST_FIX: begin
        // Divide by zero reports all-ones regardless of operand signs; the
        // remainder path already reproduces the dividend.
        quot_d  = dz_q ? DIV_ZERO_QUOT : neg_if(qneg_q, dq_q);
        remo_d  = neg_if(rneg_q, rem_q[DIV_WIDTH-1:0]);
        state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  assign A_div_busy      = (state_q == ST_PREP) || (state_q == ST_ITER) || (state_q == ST_FIX);
  assign A_div_done      = (state_q == ST_DONE);
  assign A_div_quotient  = quot_q;
  assign A_div_remainder = remo_q;

endmodule

// File: tb/tb_qsys_system_nios2_qsys_0_div_cell.sv
// Directed and random bench for the divide cell, using an expected-result queue.
module tb_qsys_system_nios2_qsys_0_div_cell;
  import qsys_system_nios2_qsys_0_div_cell_pkg::*;

  logic        clk;
  logic        reset_n;
  logic        A_div_start;
  logic        A_div_signed;
  logic [31:0] A_div_src1;
  logic [31:0] A_div_src2;
  logic        A_div_busy;
  logic        A_div_done;
  logic [31:0] A_div_quotient;
  logic [31:0] A_div_remainder;

  typedef struct packed {
    logic [31:0] q;
    logic [31:0] r;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  qsys_system_nios2_qsys_0_div_cell #(.DIV_WIDTH(32)) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .A_div_start     (A_div_start),
    .A_div_signed    (A_div_signed),
    .A_div_src1      (A_div_src1),
    .A_div_src2      (A_div_src2),
    .A_div_busy      (A_div_busy),
    .A_div_done      (A_div_done),
    .A_div_quotient  (A_div_quotient),
    .A_div_remainder (A_div_remainder)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic void ref_div(input bit sgn, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] q, output logic [31:0] r);
    longint sa, sbv;
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF;
      r = a;
    end else if (sgn) begin
      sa  = longint'(signed'(a));
      sbv = longint'(signed'(b));
      q   = 32'(sa / sbv);
      r   = 32'(sa % sbv);
    end else begin
      q = a / b;
      r = a % b;
    end
  endfunction

  // Drives start at the current (falling-edge) time; the next rising edge samples it.
  task automatic start_op(input bit sgn, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] eq, input logic [31:0] er);
    exp_t e;
    e.q = eq;
    e.r = er;
    sb.push_back(e);
    A_div_signed = sgn;
    A_div_src1   = a;
    A_div_src2   = b;
    A_div_start  = 1'b1;
  endtask

  // Counts falling edges after start until done; scrambles inputs once the
  // operation is accepted and optionally pokes start while busy.
  task automatic wait_done(input string tag, input bit poke);
    int   k;
    bit   seen;
    exp_t e;
    k    = 0;
    seen = 1'b0;
    while (!seen && k < 60) begin
      @(negedge clk);
      k++;
      if (k == 1) begin
        A_div_start  = 1'b0;
        A_div_src1   = $urandom;
        A_div_src2   = $urandom;
        A_div_signed = 1'($urandom_range(0, 1));
        check({tag, ":busy_after_start"}, 32'(A_div_busy), 32'd1);
      end
      if (poke && k == 10) A_div_start = 1'b1;
      if (poke && k == 11) A_div_start = 1'b0;
      if (A_div_done) seen = 1'b1;
    end
    check({tag, ":latency"}, 32'(k), 32'(DIV_LATENCY));
    if (sb.size() == 0) begin
      check({tag, ":scoreboard_empty"}, 32'(sb.size()), 32'd1);
    end else begin
      e = sb.pop_front();
      check({tag, ":quotient"}, A_div_quotient, e.q);
      check({tag, ":remainder"}, A_div_remainder, e.r);
    end
    check({tag, ":busy_at_done"}, 32'(A_div_busy), 32'd0);
    @(negedge clk);
    check({tag, ":done_one_cycle"}, 32'(A_div_done), 32'd0);
  endtask

  initial begin
    int          dones;
    logic [31:0] a, b, q, r;
    bit          sgn;

    reset_n      = 1'b0;
    A_div_start  = 1'b0;
    A_div_signed = 1'b0;
    A_div_src1   = '0;
    A_div_src2   = '0;
    repeat (3) @(negedge clk);
    check("rst:busy", 32'(A_div_busy), 32'd0);
    check("rst:done", 32'(A_div_done), 32'd0);
    check("rst:quotient", A_div_quotient, 32'd0);
    check("rst:remainder", A_div_remainder, 32'd0);

    // First start sampled on the first rising edge after reset release.
    reset_n = 1'b1;
    start_op(1'b0, 32'd100, 32'd7, 32'd14, 32'd2);
    wait_done("u100_7", 1'b0);

    start_op(1'b1, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, 32'hFFFF_FFFE);
    wait_done("s-100_7", 1'b0);
    start_op(1'b1, 32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF2, 32'd2);
    wait_done("s100_-7", 1'b0);
    start_op(1'b0, 32'h1234_5678, 32'd0, 32'hFFFF_FFFF, 32'h1234_5678);
    wait_done("u_div0", 1'b0);
    start_op(1'b1, 32'h1234_5678, 32'd0, 32'hFFFF_FFFF, 32'h1234_5678);
    wait_done("s_div0", 1'b0);
    start_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0);
    wait_done("s_min_-1", 1'b0);
    start_op(1'b0, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0);
    wait_done("u_max_1", 1'b0);

    // Start pulsed mid-operation must be ignored; the next op follows done directly.
    start_op(1'b0, 32'd1000, 32'd3, 32'd333, 32'd1);
    wait_done("busy_poke", 1'b1);
    start_op(1'b0, 32'd77, 32'd5, 32'd15, 32'd2);
    wait_done("back_to_back", 1'b0);

    // Reset during a divide: outputs clear at once and no done follows.
    start_op(1'b0, 32'h0000_DEAD, 32'h10, 32'h0DEA, 32'hD);
    dones = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (k == 1) A_div_start = 1'b0;
      if (A_div_done) dones++;
    end
    reset_n = 1'b0;
    #1;
    check("midrst:quotient", A_div_quotient, 32'd0);
    check("midrst:remainder", A_div_remainder, 32'd0);
    check("midrst:busy", 32'(A_div_busy), 32'd0);
    check("midrst:done", 32'(A_div_done), 32'd0);
    void'(sb.pop_back());
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (40) begin
      @(negedge clk);
      if (A_div_done) dones++;
    end
    check("midrst:no_done", 32'(dones), 32'd0);

    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    start_op(1'b1, 32'hFFFF_FC18, 32'd10, 32'hFFFF_FF9C, 32'd0);
    wait_done("start_after_rst", 1'b0);

    for (int i = 0; i < 1000; i++) begin
      sgn = 1'($urandom_range(0, 1));
      a   = $urandom;
      b   = $urandom;
      case ($urandom_range(0, 15))
        0:       b = 32'd0;
        1:       b = 32'd1;
        2:       b = 32'hFFFF_FFFF;
        3:       a = 32'h8000_0000;
        4:       b = 32'($urandom_range(1, 255));
        5:       a = 32'($urandom_range(0, 1000));
        default: ;
      endcase
      ref_div(sgn, a, b, q, r);
      start_op(sgn, a, b, q, r);
      wait_done($sformatf("rnd%0d", i), 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/qsys_system_nios2_qsys_0_div_cell.md
QSYS_SYSTEM_NIOS2_QSYS_0_DIV_CELL -- requirements
Module: Qsys_system_nios2_qsys_0_div_cell

Interface
REQ-001 SHALL have parameter DIV_WIDTH, default 32: operand/result width; only 32 is supported.
REQ-002 SHALL have port clk  input  1  single clock, rising-edge.
REQ-003 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port A_div_start  input  1  one-cycle request; operands sampled with it.
REQ-005 SHALL have port A_div_signed  input  1  1 = two's-complement divide, 0 = unsigned; sampled with start.
REQ-006 SHALL have port A_div_src1  input  32  dividend.
REQ-007 SHALL have port A_div_src2  input  32  divisor.
REQ-008 SHALL have port A_div_busy  output  1  high from the cycle after an accepted start until done.
REQ-009 SHALL have port A_div_done  output  1  one-cycle pulse; quotient and remainder valid.
REQ-010 SHALL have port A_div_quotient  output  32  quotient, held until the next accepted start.
REQ-011 SHALL have port A_div_remainder  output  32  remainder, held until the next accepted start.

Function
REQ-012 SHALL implement the FSM IDLE -> PREP -> ITER -> FIX -> DONE -> IDLE.
REQ-013 SHALL accept a start only in IDLE; a start in any other state is ignored without side effects.
REQ-014 SHALL latch src1, src2 and signed on the accepting edge, so later input changes have no effect.
REQ-015 PREP SHALL form unsigned magnitudes (absolute values when signed=1), record quotient sign = sign1 XOR sign2 and remainder sign = sign1, clear the partial remainder, and load a 6-bit counter with 0.
REQ-016 ITER SHALL perform one radix-2 restoring step per cycle: shift the remainder left by one, shift in the next dividend MSB, subtract the divisor when the remainder >= divisor, set the quotient bit; exactly 32 cycles, then go to FIX.
REQ-017 FIX SHALL negate the quotient and/or remainder per the recorded signs and register both outputs.
REQ-018 DONE SHALL assert A_div_done for exactly one cycle, deassert busy, and return to IDLE.
REQ-019 Latency: done SHALL be high exactly 35 cycles after the cycle in which start was sampled high; throughput is one divide per 36 cycles.
REQ-020 A new start SHALL be accepted in the cycle immediately after done.
REQ-021 Divide by zero SHALL return quotient 0xFFFFFFFF and remainder = src1, in both signed and unsigned mode, with normal latency.
REQ-022 Signed 0x80000000 / 0xFFFFFFFF SHALL return quotient 0x80000000 and remainder 0, with no trap.
REQ-023 Signed results SHALL truncate toward zero, with the remainder taking the sign of the dividend.
REQ-024 The internal datapath SHALL be 33 bits for the remainder/compare and 32 bits for the quotient, and SHALL use no DSP blocks.

Reset
REQ-025 reset_n low SHALL asynchronously force IDLE, busy=0, done=0, quotient=0, remainder=0, counter=0.
REQ-026 Reset asserted mid-operation SHALL abandon the divide; no done pulse SHALL follow reset release.
REQ-027 The first start SHALL be accepted on the first rising edge after reset_n deasserts.

Structure
REQ-028 A shared package SHALL hold the FSM state enum, DIV_WIDTH, DIV_LATENCY=35 and the divide-by-zero quotient constant 0xFFFFFFFF.
REQ-029 The single restoring step SHALL be one combinational sub-module, Qsys_system_nios2_qsys_0_div_step, instantiated once inside the FSM datapath.
REQ-030 The total RTL SHALL be 120-400 lines, with all state registers on clk/reset_n only.

Verification
REQ-031 The bench SHALL drive unsigned 100/7 -> quotient 14, remainder 2, with done exactly 35 cycles after start.
REQ-032 The bench SHALL drive signed -100/7 (0xFFFFFF9C/7) -> quotient 0xFFFFFFF2, remainder 0xFFFFFFFE; and 100/-7 -> quotient 0xFFFFFFF2, remainder 2.
REQ-033 The bench SHALL drive signed and unsigned 0x12345678/0 -> quotient 0xFFFFFFFF, remainder 0x12345678.
REQ-034 The bench SHALL drive signed 0x80000000/0xFFFFFFFF -> quotient 0x80000000, remainder 0; and unsigned 0xFFFFFFFF/1 -> quotient 0xFFFFFFFF, remainder 0.
REQ-035 The bench SHALL pulse start again at cycle 10 while busy -> it is ignored and the first result is unchanged; then start in the cycle after done -> accepted.
REQ-036 The bench SHALL assert reset_n low at cycle 20 of a divide -> outputs go to 0 immediately with no done pulse; then run 1000 random signed/unsigned operand pairs and compare against a reference model.
